// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: UART receiver feeding a show-ahead byte FIFO with overflow and frame/parity error reporting.
// Define UART_CMD_RX_PARITY_EN to compile in the parity bit and checking (PARITY: 0 none, 1 odd, 2 even).
module uart_cmd_rx #(
  parameter int unsigned MAIN_CLK_FREQ = 120000000,
  parameter int unsigned UART_BAUD     = 115200,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned PARITY        = 0,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned AF_LEVEL      = FIFO_DEPTH - 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rx,
  input  logic                          data_en,
  input  logic                          ovf_clr,
  output logic                          data_ready,
  output logic [7:0]                    data,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          almost_full,
  output logic                          overflow_flag,
  output logic                          frame_err,
  output logic                          parity_err
);

  localparam int unsigned CLKS_PER_BIT = MAIN_CLK_FREQ / UART_BAUD;
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY > 2 || FIFO_DEPTH < 2) begin : g_bad_cfg
    $error("uart_cmd_rx: illegal DATA_BITS, PARITY or FIFO_DEPTH");
  end

`ifdef UART_CMD_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

  // Reset asserts asynchronously but releases on a clock edge.
  logic rst_m, rst_i;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) {rst_i, rst_m} <= 2'b00;
    else      {rst_i, rst_m} <= {rst_m, 1'b1};
  end

  // Line synchronizer is released ahead of the FSM so it holds real line samples once the FSM starts.
  logic rx_m, rx_s;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= uart_rx;
      rx_s <= rx_m;
    end
  end

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 armed;
  logic                 push;
  logic                 par_bad;

  // Receiver: armed only after the line is seen high, so a character cut by reset is not resumed.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      armed     <= 1'b0;
      push      <= 1'b0;
      par_bad   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      push      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          par_bad <= 1'b0;
          if (!armed)     armed <= rx_s;
          else if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == CW'(CLKS_PER_BIT / 2)) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == BW'(DATA_BITS - 1)) begin
`ifdef UART_CMD_RX_PARITY_EN
              state <= (PARITY != 0) ? PAR : STOP;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_CMD_RX_PARITY_EN
        PAR: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt     <= '0;
            par_bad <= rx_s != ((^shreg) ^ (PARITY == 1));
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt       <= '0;
            frame_err <= !rx_s;
`ifdef UART_CMD_RX_PARITY_EN
            parity_err <= par_bad;
`endif
            push      <= rx_s && !par_bad;
            state     <= rx_s ? IDLE : WAIT_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: if (rx_s) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

`ifndef UART_CMD_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [LW-1:0] lvl_next;
  logic [7:0]    push_byte, head_next;
  logic          do_push, do_pop, drop;

  // FIFO control; a push into a full FIFO only lands when the same cycle pops.
  always_comb begin
    push_byte                  = '0;
    push_byte[DATA_BITS-1:0]   = shreg;
    do_pop                     = data_en && (level != '0);
    do_push                    = push && ((level != LW'(FIFO_DEPTH)) || data_en);
    drop                       = push && !do_push;
    lvl_next                   = level + LW'(do_push) - LW'(do_pop);
    rd_next                    = rd_ptr + AW'(do_pop);
    if (lvl_next == '0)                          head_next = '0;
    else if (do_push && (level == LW'(do_pop)))  head_next = push_byte;
    else                                         head_next = mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      data_ready    <= 1'b0;
      almost_full   <= 1'b0;
      data          <= '0;
      overflow_flag <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr + AW'(do_push);
      rd_ptr        <= rd_next;
      level         <= lvl_next;
      data_ready    <= lvl_next != '0;
      almost_full   <= lvl_next >= LW'(AF_LEVEL);
      data          <= head_next;
      overflow_flag <= drop | (overflow_flag & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: 16 clocks per bit, 4-entry FIFO, hand-computed expectations.
module tb_uart_cmd_rx;

  localparam int unsigned BIT_CLKS = 16;
`ifdef UART_CMD_RX_PARITY_EN
  localparam int unsigned PAR_CFG = 2;
`else
  localparam int unsigned PAR_CFG = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_rx = 1'b1;
  logic       data_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       data_ready;
  logic [7:0] data;
  logic [2:0] level;
  logic       almost_full, overflow_flag, frame_err, parity_err;

  int n_checks = 0;
  int n_fails  = 0;
  int fe_cnt   = 0;
  int pe_cnt   = 0;
  int fe0, pe0;

  uart_cmd_rx #(
    .MAIN_CLK_FREQ(16), .UART_BAUD(1), .DATA_BITS(8), .PARITY(PAR_CFG), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .data_en(data_en), .ovf_clr(ovf_clr),
    .data_ready(data_ready), .data(data), .level(level), .almost_full(almost_full),
    .overflow_flag(overflow_flag), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err)  fe_cnt++;
    if (parity_err) pe_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic has_par, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (has_par) drive_bit(par);
    drive_bit(stop);
    drive_bit(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!data_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(data_ready), 32'd1);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check_eq(tag, 32'(data), 32'(exp));
    data_en = 1'b1;
    @(negedge clk);
    data_en = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({data_ready, data, level, almost_full, overflow_flag, frame_err, parity_err});
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", all_outs(), 32'd0);
    rst = 1'b1;
    repeat (40) @(negedge clk);

    // Two bytes, read back in order.
    send_byte(8'hA5);
    wait_ready("a5_ready");
    check_eq("a5_level", 32'(level), 32'd1);
    send_byte(8'h3C);
    check_eq("two_level", 32'(level), 32'd2);
    pop_expect("read_a5", 8'hA5);
    pop_expect("read_3c", 8'h3C);
    check_eq("empty_level", 32'(level), 32'd0);
    check_eq("empty_ready", 32'(data_ready), 32'd0);
    data_en = 1'b1;
    @(negedge clk);
    data_en = 1'b0;
    check_eq("pop_empty_level", 32'(level), 32'd0);

    // Overflow: five bytes into four entries.
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    check_eq("full_level", 32'(level), 32'd4);
    check_eq("full_af", 32'(almost_full), 32'd1);
    check_eq("ovf_set", 32'(overflow_flag), 32'd1);
    for (int i = 1; i <= 4; i++) pop_expect("ovf_read", 8'(i));
    check_eq("drained_level", 32'(level), 32'd0);
    check_eq("drained_af", 32'(almost_full), 32'd0);
    check_eq("ovf_sticky", 32'(overflow_flag), 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check_eq("ovf_clr", 32'(overflow_flag), 32'd0);

    // False start: short low glitch.
    fe0 = fe_cnt;
    pe0 = pe_cnt;
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    check_eq("glitch_level", 32'(level), 32'd0);
    check_eq("glitch_errs", 32'(fe_cnt - fe0 + pe_cnt - pe0), 32'd0);
    send_byte(8'h5A);
    wait_ready("after_glitch_ready");
    pop_expect("after_glitch_data", 8'h5A);

    // Framing error, then recovery.
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    check_eq("frame_err_pulses", 32'(fe_cnt - fe0), 32'd1);
    check_eq("frame_err_level", 32'(level), 32'd0);
    send_byte(8'h66);
    wait_ready("after_fe_ready");
    pop_expect("after_fe_data", 8'h66);

    // Parity (even) or, without it, parity_err never fires.
    pe0 = pe_cnt;
`ifdef UART_CMD_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    check_eq("parity_err_pulses", 32'(pe_cnt - pe0), 32'd1);
    check_eq("parity_err_level", 32'(level), 32'd0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    wait_ready("parity_ok_ready");
    pop_expect("parity_ok_data", 8'h07);
    check_eq("parity_ok_pulses", 32'(pe_cnt - pe0), 32'd1);
`else
    send_byte(8'h07);
    wait_ready("nopar_ready");
    pop_expect("nopar_data", 8'h07);
    check_eq("nopar_pulses", 32'(pe_cnt - pe0), 32'd0);
`endif

    // Reset during data bit 3 of 0xFF with one byte already queued.
    send_byte(8'h3C);
    check_eq("pre_rst_ready", 32'(data_ready), 32'd1);
    uart_rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_outputs", all_outs(), 32'd0);
    repeat (4) @(negedge clk);
    check_eq("held_rst_outputs", all_outs(), 32'd0);
    rst = 1'b1;
    repeat (8 * BIT_CLKS) @(negedge clk);
    check_eq("post_rst_level", 32'(level), 32'd0);
    send_byte(8'h12);
    wait_ready("post_rst_ready");
    check_eq("post_rst_one", 32'(level), 32'd1);
    pop_expect("post_rst_data", 8'h12);
    check_eq("final_level", 32'(level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
